mem_access_unit: RTL

MEM-stage load/store unit that consumes the EX/MEM pipeline payload (ALU result, store data, funct3, control bits) and produces a registered MEM/WB payload. It drives a single-outstanding req/ack data-memory port, aligns store data and byte strobes, and sign- or zero-extends load data. It stalls the upstream stages while a memory access is pending and flags misaligned or illegal accesses and ack timeouts.

---
 rtl/mem_access_unit.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: single-outstanding req/ack data port, store lane
// alignment, load extension, and a registered MEM/WB payload with fault flag.
module mem_access_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [DATA_WIDTH-1:0] rd_data2_i,
    input  logic [2:0]            funct3_i,
    input  logic [4:0]            rd_addr_i,
    input  logic [DATA_WIDTH-1:0] pc_plus4_i,
    input  logic                  RegWrite_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic [1:0]            WBSel_i,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_wstrb_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic                  wb_valid_o,
    output logic [4:0]            wb_rd_addr_o,
    output logic                  wb_RegWrite_o,
    output logic [1:0]            wb_WBSel_o,
    output logic [DATA_WIDTH-1:0] wb_alu_result_o,
    output logic [DATA_WIDTH-1:0] wb_pc_plus4_o,
    output logic [DATA_WIDTH-1:0] wb_mem_data_o,
    output logic                  wb_fault_o
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]      cnt_q;
    logic [1:0]            off_q;
    logic [2:0]            f3_q;
    logic [4:0]            p_rd_addr;
    logic                  p_regwrite;
    logic [1:0]            p_wbsel;
    logic [DATA_WIDTH-1:0] p_alu;
    logic [DATA_WIDTH-1:0] p_pc4;

    logic                  is_access;
    logic                  size_ok;
    logic                  legal;
    logic                  accept;
    logic                  complete;
    logic                  timeout;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [3:0]            st_wstrb;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] ld_data;

    // Access legality: size/alignment from funct3, unsigned loads are read-only.
    always_comb begin
        is_access = in_valid_i && (MemRead_i || MemWrite_i);
        size_ok   = 1'b0;
        case (funct3_i)
            3'b000, 3'b100: size_ok = 1'b1;
            3'b001, 3'b101: size_ok = ~alu_result_i[0];
            3'b010:         size_ok = (alu_result_i[1:0] == 2'b00);
            default:        size_ok = 1'b0;
        endcase
        legal = size_ok
              && !(MemRead_i && MemWrite_i)
              && !(funct3_i[2] && MemWrite_i);
    end

    always_comb begin
        st_wdata = rd_data2_i;
        st_wstrb = 4'b1111;
        case (funct3_i[1:0])
            2'b00: begin
                st_wdata = {4{rd_data2_i[7:0]}};
                st_wstrb = 4'b0001 << alu_result_i[1:0];
            end
            2'b01: begin
                st_wdata = {2{rd_data2_i[15:0]}};
                st_wstrb = 4'b0011 << alu_result_i[1:0];
            end
            default: begin
                st_wdata = rd_data2_i;
                st_wstrb = 4'b1111;
            end
        endcase
        if (!MemWrite_i) begin
            st_wstrb = '0;
        end
    end

    always_comb begin
        shifted = mem_rdata_i >> {off_q, 3'b000};
        ld_data = '0;
        case (f3_q)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ld_data = {24'b0, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ld_data = {16'b0, shifted[15:0]};
            3'b010:  ld_data = mem_rdata_i;
            default: ld_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset gates everything so stall_o is low in the reset cycle.
    always_comb begin
        state_d  = state_q;
        stall_o  = 1'b0;
        accept   = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (is_access && legal) begin
                        accept  = 1'b1;
                        stall_o = 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    stall_o = ~mem_ack_i;
                    if (mem_ack_i) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout = 1'b1;
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q           <= '0;
            off_q           <= '0;
            f3_q            <= '0;
            p_rd_addr       <= '0;
            p_regwrite      <= 1'b0;
            p_wbsel         <= '0;
            p_alu           <= '0;
            p_pc4           <= '0;
            mem_req_o       <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= '0;
            mem_wdata_o     <= '0;
            mem_wstrb_o     <= '0;
            wb_valid_o      <= 1'b0;
            wb_rd_addr_o    <= '0;
            wb_RegWrite_o   <= 1'b0;
            wb_WBSel_o      <= '0;
            wb_alu_result_o <= '0;
            wb_pc_plus4_o   <= '0;
            wb_mem_data_o   <= '0;
            wb_fault_o      <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            if (accept) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= MemWrite_i;
                mem_addr_o  <= {alu_result_i[DATA_WIDTH-1:2], 2'b00};
                mem_wdata_o <= st_wdata;
                mem_wstrb_o <= st_wstrb;
                off_q       <= alu_result_i[1:0];
                f3_q        <= funct3_i;
                p_rd_addr   <= rd_addr_i;
                p_regwrite  <= RegWrite_i;
                p_wbsel     <= WBSel_i;
                p_alu       <= alu_result_i;
                p_pc4       <= pc_plus4_i;
                cnt_q       <= '0;
            end else if (state_q == IDLE && in_valid_i) begin
                // Non-access or faulting access retires immediately without a request.
                wb_valid_o      <= 1'b1;
                wb_rd_addr_o    <= rd_addr_i;
                wb_RegWrite_o   <= RegWrite_i && !is_access;
                wb_WBSel_o      <= WBSel_i;
                wb_alu_result_o <= alu_result_i;
                wb_pc_plus4_o   <= pc_plus4_i;
                wb_mem_data_o   <= '0;
                wb_fault_o      <= is_access;
            end else if (complete || timeout) begin
                mem_req_o       <= 1'b0;
                wb_valid_o      <= 1'b1;
                wb_rd_addr_o    <= p_rd_addr;
                wb_RegWrite_o   <= p_regwrite && complete;
                wb_WBSel_o      <= p_wbsel;
                wb_alu_result_o <= p_alu;
                wb_pc_plus4_o   <= p_pc4;
                wb_mem_data_o   <= (complete && !mem_we_o) ? ld_data : '0;
                wb_fault_o      <= timeout;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule
